fifo_action_driver: RTL and testbench

Action-driven stimulus engine for the `fifo` block. An RL agent supplies one action per handshake: an operation code and a beat count. The engine replays that action as cycle-accurate `push`/`pop`/`datain` traffic into the FIFO and checks read data against an in-order model. After the burst it returns per-action observations that the agent uses as reward inputs: full/empty edge hits, blocked beats, final occupancy and data errors.

---
 rtl/fifo_action_driver.sv | 156 +++++++++++++++
 tb/tb_fifo_action_driver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_action_driver.sv
// Turns one agent action (op + beat count) into push/pop/datain traffic for an attached FIFO.
// It also checks read data in order and reports per-action observations.
module fifo_action_driver #(
  parameter int unsigned width     = 8,
  parameter int unsigned depth     = 8,
  parameter int unsigned log2depth = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 act_valid,
  output logic                 act_ready,
  input  logic [1:0]           act_op,
  input  logic [3:0]           act_len,
  output logic                 push,
  output logic                 pop,
  output logic [width-1:0]     datain,
  input  logic [width-1:0]     dataout,
  input  logic                 full_posedge,
  input  logic                 empty_posedge,
  output logic                 done_valid,
  output logic [3:0]           res_full_hits,
  output logic [3:0]           res_empty_hits,
  output logic [3:0]           res_blocked,
  output logic [log2depth:0]   res_occ,
  output logic [7:0]           err_cnt,
  output logic                 err_sticky
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [log2depth:0] OccMax = (log2depth + 1)'(depth);

  state_e               state_q, state_d;
  logic [1:0]           op_q;
  logic [3:0]           beats_q;
  logic [log2depth:0]   occ_q;
  logic [width-1:0]     wr_seq_q, rd_seq_q;
  logic [3:0]           full_hits_q, empty_hits_q, blocked_q;
  logic [7:0]           err_cnt_q;
  logic                 err_sticky_q;

  logic in_run, accept;
  logic want_push, want_pop;
  logic push_iss, pop_iss, beat_blocked, rd_mismatch;

  // Gating uses only the shadow occupancy so no path depends on the FIFO flags.
  always_comb begin
    in_run       = (state_q == StRun);
    accept       = (state_q == StIdle) && act_valid;
    want_push    = in_run && op_q[0];
    want_pop     = in_run && op_q[1];
    pop_iss      = want_pop && (occ_q != '0);
    push_iss     = want_push && ((occ_q != OccMax) || pop_iss);
    beat_blocked = (want_push && !push_iss) || (want_pop && !pop_iss);
    rd_mismatch  = pop_iss && (dataout != rd_seq_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (act_valid) begin
          state_d = (act_len == 4'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (beats_q == 4'd1) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    act_ready  = (state_q == StIdle);
    done_valid = (state_q == StDone);
    push       = push_iss;
    pop        = pop_iss;
    datain     = wr_seq_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= 2'b00;
      beats_q      <= 4'd0;
      occ_q        <= '0;
      wr_seq_q     <= '0;
      rd_seq_q     <= '0;
      full_hits_q  <= 4'd0;
      empty_hits_q <= 4'd0;
      blocked_q    <= 4'd0;
      err_cnt_q    <= 8'd0;
      err_sticky_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q         <= act_op;
        beats_q      <= act_len;
        full_hits_q  <= 4'd0;
        empty_hits_q <= 4'd0;
        blocked_q    <= 4'd0;
      end

      if (in_run) begin
        beats_q <= beats_q - 4'd1;
        if (full_posedge && (full_hits_q != 4'hF)) begin
          full_hits_q <= full_hits_q + 4'd1;
        end
        if (empty_posedge && (empty_hits_q != 4'hF)) begin
          empty_hits_q <= empty_hits_q + 4'd1;
        end
        if (beat_blocked && (blocked_q != 4'hF)) begin
          blocked_q <= blocked_q + 4'd1;
        end
      end

      if (push_iss && !pop_iss) begin
        occ_q <= occ_q + 1'b1;
      end else if (pop_iss && !push_iss) begin
        occ_q <= occ_q - 1'b1;
      end

      if (push_iss) begin
        wr_seq_q <= wr_seq_q + 1'b1;
      end
      if (pop_iss) begin
        rd_seq_q <= rd_seq_q + 1'b1;
      end

      if (rd_mismatch) begin
        err_sticky_q <= 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

  // Occupancy only moves during RUN, so it already holds between actions.
  assign res_full_hits  = full_hits_q;
  assign res_empty_hits = empty_hits_q;
  assign res_blocked    = blocked_q;
  assign res_occ        = occ_q;
  assign err_cnt        = err_cnt_q;
  assign err_sticky     = err_sticky_q;

endmodule

// File: tb/tb_fifo_action_driver.sv
// Scoreboard bench for fifo_action_driver driving a small behavioural FIFO.
// Expected results and pushed data are queued at stimulus time and checked by monitors.
module tb_fifo_action_driver;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk;
  logic         rst;
  logic         act_valid;
  logic         act_ready;
  logic [1:0]   act_op;
  logic [3:0]   act_len;
  logic         push, pop;
  logic [W-1:0] datain, dataout;
  logic         full_posedge, empty_posedge;
  logic         done_valid;
  logic [3:0]   res_full_hits, res_empty_hits, res_blocked;
  logic [3:0]   res_occ;
  logic [7:0]   err_cnt;
  logic         err_sticky;
  logic         corrupt;

  fifo_action_driver #(.width(W), .depth(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .act_valid     (act_valid),
    .act_ready     (act_ready),
    .act_op        (act_op),
    .act_len       (act_len),
    .push          (push),
    .pop           (pop),
    .datain        (datain),
    .dataout       (dataout),
    .full_posedge  (full_posedge),
    .empty_posedge (empty_posedge),
    .done_valid    (done_valid),
    .res_full_hits (res_full_hits),
    .res_empty_hits(res_empty_hits),
    .res_blocked   (res_blocked),
    .res_occ       (res_occ),
    .err_cnt       (err_cnt),
    .err_sticky    (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: edge outputs fire in the cycle whose push/pop makes it full/empty.
  logic [W-1:0] mem [D];
  logic [2:0]   wp, rp;
  logic [3:0]   cnt;
  logic         f_push, f_pop;

  assign f_pop         = pop && (cnt != 4'd0);
  assign f_push        = push && ((cnt != 4'd8) || f_pop);
  assign dataout       = mem[rp] ^ {7'b0, corrupt};
  assign full_posedge  = f_push && !f_pop && (cnt == 4'd7);
  assign empty_posedge = f_pop && !f_push && (cnt == 4'd1);

  always @(posedge clk) begin
    if (rst) begin
      wp  <= 3'd0;
      rp  <= 3'd0;
      cnt <= 4'd0;
    end else begin
      if (f_push) begin
        mem[wp] <= datain;
        wp      <= wp + 3'd1;
      end
      if (f_pop) rp <= rp + 3'd1;
      cnt <= cnt + 4'(f_push) - 4'(f_pop);
    end
  end

  typedef struct {
    int full;
    int empty;
    int blocked;
    int occ;
    int errc;
    int sticky;
    int lat;
  } res_t;

  res_t exp_q[$];
  int   push_q[$];
  int   acc_q[$];
  int   acc_all[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic res_t mk(input int f, input int e, input int b, input int o,
                              input int ec, input int s, input int l);
    res_t r;
    r.full = f; r.empty = e; r.blocked = b; r.occ = o;
    r.errc = ec; r.sticky = s; r.lat = l;
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst && act_valid && act_ready) begin
      acc_q.push_back(cyc);
      acc_all.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  res_t me;
  int   ma;
  always @(negedge clk) begin
    if (push) begin
      if (push_q.size() == 0) chk("unexpected_push", 1, 0);
      else chk("datain", int'(datain), push_q.pop_front());
    end
    if (done_valid) begin
      n_done++;
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        me = exp_q.pop_front();
        ma = acc_q.pop_front();
        chk("res_full_hits", int'(res_full_hits), me.full);
        chk("res_empty_hits", int'(res_empty_hits), me.empty);
        chk("res_blocked", int'(res_blocked), me.blocked);
        chk("res_occ", int'(res_occ), me.occ);
        chk("err_cnt", int'(err_cnt), me.errc);
        chk("err_sticky", int'(err_sticky), me.sticky);
        chk("done_latency", cyc - ma, me.lat);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] len, input res_t e);
    int b;
    @(negedge clk);
    act_op    = op;
    act_len   = len;
    act_valid = 1'b1;
    exp_q.push_back(e);
    b = 0;
    while (!act_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!act_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    act_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int b;
    b = 0;
    while (n_done < target && b < 40) begin
      @(posedge clk);
      b++;
    end
    if (n_done < target) chk("done_timeout", n_done, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ia;
    rst       = 1'b1;
    act_valid = 1'b0;
    act_op    = 2'b00;
    act_len   = 4'd0;
    corrupt   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_act_ready", int'(act_ready), 1);
    chk("rst_push", int'(push), 0);
    chk("rst_pop", int'(pop), 0);
    chk("rst_datain", int'(datain), 0);
    chk("rst_done_valid", int'(done_valid), 0);
    chk("rst_res_sum", int'(res_full_hits) + int'(res_empty_hits) + int'(res_blocked)
        + int'(res_occ), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_err_sticky", int'(err_sticky), 0);
    rst = 1'b0;

    // Fill an empty FIFO: data 0..7, one full edge.
    for (int i = 0; i < 8; i++) push_q.push_back(i);
    issue(2'b01, 4'd8, mk(1, 0, 0, 8, 0, 0, 9));
    wait_done(1);
    repeat (3) @(negedge clk);
    chk("hold_res_occ", int'(res_occ), 8);
    chk("hold_res_full_hits", int'(res_full_hits), 1);

    // Push into full: all blocked.
    issue(2'b01, 4'd3, mk(0, 0, 3, 8, 0, 0, 4));
    wait_done(2);

    // Drain and over-pop.
    issue(2'b10, 4'd10, mk(0, 1, 2, 0, 0, 0, 11));
    wait_done(3);

    // Push+pop from empty: first beat push only.
    for (int i = 8; i < 12; i++) push_q.push_back(i);
    issue(2'b11, 4'd4, mk(0, 0, 1, 1, 0, 0, 5));
    wait_done(4);

    // Zero-length action, then valid held high through a second action.
    ia = acc_all.size();
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 4));
    @(negedge clk);
    act_op    = 2'b01;
    act_len   = 4'd0;
    act_valid = 1'b1;
    @(negedge clk);
    act_op  = 2'b00;
    act_len = 4'd3;
    wait_done(6);
    @(negedge clk);
    act_valid = 1'b0;
    if (acc_all.size() >= ia + 2) chk("accept_gap", acc_all[ia+1] - acc_all[ia], 2);
    else chk("accept_count_overlap", acc_all.size() - ia, 2);

    // Corrupted read data must be counted.
    corrupt = 1'b1;
    issue(2'b10, 4'd1, mk(0, 1, 0, 0, 1, 1, 2));
    wait_done(7);
    @(negedge clk);
    corrupt = 1'b0;

    // Reset during beat 3 of a push burst.
    push_q.push_back(12);
    push_q.push_back(13);
    push_q.push_back(14);
    @(negedge clk);
    act_op    = 2'b01;
    act_len   = 4'd10;
    act_valid = 1'b1;
    @(negedge clk);
    act_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
    chk("abort_act_ready", int'(act_ready), 1);
    chk("abort_push", int'(push), 0);
    chk("abort_datain", int'(datain), 0);
    chk("abort_res_occ", int'(res_occ), 0);
    chk("abort_err_cnt", int'(err_cnt), 0);
    chk("abort_err_sticky", int'(err_sticky), 0);
    repeat (20) @(posedge clk);
    chk("abort_no_done", n_done, 7);

    push_q.push_back(0);
    issue(2'b01, 4'd1, mk(0, 0, 0, 1, 0, 0, 2));
    wait_done(8);

    repeat (3) @(negedge clk);
    chk("leftover_push_q", push_q.size(), 0);
    chk("leftover_exp_q", exp_q.size(), 0);
    chk("accept_total", acc_all.size(), 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
